serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial addition controller built around a single instance of the team's `full_adder` cell (ports p, q, r, sum, carry). It captures two WIDTH-bit operands on a start request and streams them LSB-first through that one full adder, one bit per clock, holding the running carry in a flip-flop. It then presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the area-minimal adder option for the arithmetic datapath, trading latency for a single adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset; clears all state immediately
- start  input  1  request; sampled on rising edge in IDLE or DONE only
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse; high while in DONE
- sum  output  WIDTH  result register; changes only at completion
- cout  output  1  carry-out register; changes only at completion

## Operation
- Datapath:
  - Two WIDTH-bit shift registers hold A and B, shifting right.
  - Bit 0 of each register drives the full_adder p and q inputs.
  - The carry flip-flop drives r.
  - The full_adder sum output shifts into the MSB of a partial-sum shift register.
  - The full_adder carry output loads the carry flip-flop.
- Counter: bit counter of width $clog2(WIDTH), 0..WIDTH-1.
- FSM states: IDLE, RUN, DONE; registered, encoding free.
- IDLE:
  - start=1 -> RUN.
  - Load the A and B registers.
  - Carry flip-flop <= cin.
  - Counter <= 0.
- RUN:
  - Each edge shifts one bit and increments the counter.
  - When the counter is WIDTH-1 -> DONE.
  - On that same edge, sum <= the final partial sum (including the bit added on that edge) and cout <= the final carry.
- DONE:
  - start=1 -> RUN, loading operands as in IDLE; back-to-back operation is allowed.
  - Otherwise -> IDLE.
- start in RUN is ignored, and its operands are discarded.
- Arithmetic: {cout, sum} = a + b + cin, computed exactly over WIDTH+1 bits with no truncation beyond cout.
- Reset mid-operation: the state returns to IDLE and the partial result is discarded. sum and cout clear to 0, and done is not pulsed for the aborted operation.

## Timing
- Reset values:
  - busy=0, done=0, sum=0, cout=0.
  - State IDLE.
  - Counter, carry flip-flop and shift registers = 0.
- Take the accepting edge as E0:
  - busy is high from after E0 until after E(WIDTH).
  - sum and cout update at E(WIDTH).
  - done is high for exactly one cycle between E(WIDTH) and E(WIDTH+1).
- Latency: WIDTH cycles from the accepting edge to the done pulse.
- Throughput: with start held high, one result every WIDTH+1 cycles.
- sum and cout stay stable from E(WIDTH) until the next completion or reset; they are valid whenever done=1 and after it.
- Inputs a, b, cin and sub only need to be stable at the accepting edge.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - When sub=1 is captured, B is stored inverted and the carry flip-flop is initialised to 1; cin is ignored.
  - Result: {cout, sum} = a + ~b + 1, i.e. a − b with cout=1 meaning no borrow.
  - When sub=0 is captured, behaviour is identical to plain add.
- SERIAL_ADDER_SUB_EN undefined: there is no sub port and no inversion logic; the block is add-only.

## Test plan
- Reset then add, WIDTH=8:
  - Stimulus: a=8'h35, b=8'h4A, cin=0.
  - Response: busy=1 for 8 cycles, then done=1 for 1 cycle; sum=8'h7F, cout=0.
- Carry ripple, WIDTH=8:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start:
  - Stimulus: start a=8'h10, b=8'h20; at cycle 3 of RUN pulse start with a=8'hAA, b=8'h55.
  - Response: exactly one done pulse; sum=8'h30, cout=0; busy deasserts on schedule.
- Back-to-back:
  - Stimulus: start held high with operand pairs (8'h01, 8'h02) then (8'h80, 8'h80).
  - Response: done at cycle 8 with sum=8'h03; done again at cycle 17 with sum=8'h00, cout=1.
- Async reset mid-run:
  - Stimulus: assert rst between edges at RUN cycle 4.
  - Response: busy=0, sum=0 and cout=0 immediately, with no done pulse. A following add of 8'h07 + 8'h09 gives sum=8'h10.
- SERIAL_ADDER_SUB_EN, WIDTH=8:
  - a=8'h10, b=8'h03, sub=1 -> sum=8'h0D, cout=1.
  - a=8'h03, b=8'h10, sub=1 -> sum=8'hF3, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder controller built around one full_adder cell.
//
// Two WIDTH-bit operands are captured when start is accepted. They are
// streamed LSB-first through a single full adder, one bit per clock, with the
// running carry held in a flip-flop. The WIDTH-bit sum and the carry-out are
// registered at completion, and done pulses for one cycle.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a sub port is added. sub=1 computes a + ~b + 1 (a - b),
//   and cout=1 then means no borrow.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; accepted in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high while the serial addition is running
//   done   out  one-cycle completion pulse
//   sum    out  registered WIDTH-bit result
//   cout   out  registered carry-out

module full_adder (
    input  logic p,
    input  logic q,
    input  logic r,
    output logic sum,
    output logic carry
);
    assign sum   = p ^ q ^ r;
    assign carry = (p & q) | (r & (p ^ q));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             load, shift, last;

    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] ps_sr;      // partial sum; the newest bit enters at the top
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] ps_full;    // partial sum including this cycle's bit
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    full_adder u_fa (
        .p     (a_sr[0]),
        .q     (b_sr[0]),
        .r     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign ps_full = {fa_sum, ps_sr};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is two's complement: invert B and force a carry-in of 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                // start is ignored here; operands are not captured
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            ps_sr <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            if (load) begin
                a_sr  <= a;
                b_sr  <= b_load;
                ps_sr <= '0;
                carry <= c_load;
                cnt   <= '0;
            end else if (shift) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                ps_sr <= ps_full[WIDTH-1:1];
                carry <= fa_carry;
                cnt   <= cnt + CW'(1);
            end
            // The result is taken from the adder output on the last edge,
            // so the final bit and carry are included without an extra cycle.
            if (last) begin
                sum  <= ps_full;
                cout <= fa_carry;
            end
        end
    end
endmodule
